adder_pipe: RTL and testbench
=============================

# adder_pipe

Parametrised, pipelined N-bit adder/subtractor with carry/borrow-in and the standard Carry/Zero/Overflow flags. The operand width is split into S chunks, and one chunk is resolved per pipeline stage, with the carry registered between stages. This gives one result per cycle at S-cycle latency. It sits in the datapath wherever wide add/sub must meet timing, and carry-in/out support multi-word chaining.

## Interface
- N, 32: operand/result width in bits.
- S, 4: pipeline stages (chunks). Legal only if N % S == 0 and S ≥ 1; chunk width W = N/S.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts beat this cycle.
- in_sub  in  1  0 = A + B + cin, 1 = A − B − cin.
- in_cin  in  1  carry-in (add) / borrow-in (sub).
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts beat.
- out_result  out  N  result.
- out_carry  out  1  carry-out (add) / borrow-out (sub).
- out_zero  out  1  out_result == 0.
- out_overflow  out  1  signed two's-complement overflow.

## Operation
- Effective operand: Be = in_sub ? ~in_b : in_b.
- Effective carry-in: c0 = in_sub ? ~in_cin : in_cin.
- Full-width sum: {cout, R} = A + Be + c0, computed W bits per stage.
  - Stage k (1..S) adds chunk k−1 using the carry registered by stage k−1.
  - Unprocessed operand chunks and finished result chunks travel with the beat in stage registers.
- out_carry = cout ^ in_sub, so in sub mode 1 means a borrow occurred.
- out_overflow = (A[N−1] == Be[N−1]) && (R[N−1] != A[N−1]).
- out_zero = ~|out_result, evaluated on the delivered result.
- All arithmetic is modulo 2^N. No sign extension; operands are the same width.
- Pipeline control is global: adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv = 1, every stage shifts forward one position, and each stage's valid bit copies the previous stage's valid.
  - When adv = 0, all stage registers hold.
- A beat is accepted when in_valid && in_ready. When in_valid = 0 and adv = 1, a bubble (valid = 0) enters stage 1.
- out_* are registered outputs of stage S. out_result and flags are stable while out_valid && !out_ready.
- Reset: all stage valid bits are cleared; out_valid = 0, out_result = 0, out_carry = 0, out_zero = 0, out_overflow = 0.
  - Beats in flight are discarded, with no partial output.
  - in_ready = 1 in the first cycle after reset deasserts.

## Timing
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+S−1. The result is registered at edge t+S−1, so S = 1 gives a registered result the cycle after acceptance.
- Throughput: 1 beat/cycle while out_ready = 1.
- Back-pressure: in_ready falls in the same cycle out_valid && !out_ready holds (combinational from out_ready). No beat is lost or duplicated.
- Simultaneous out_ready fall and in_valid: the beat is not accepted, and the source must hold it.
- rst has priority over any handshake in the same cycle.

## Configuration
- ADDER_PIPE_SAT_EN defined: signed saturation is applied at stage S.
  - On out_overflow = 1, out_result = A[N−1] ? {1'b1, {N−1{1'b0}}} : {1'b0, {N−1{1'b1}}}.
  - out_overflow still reports the raw overflow. out_carry reports the raw cout ^ in_sub.
- ADDER_PIPE_SAT_EN undefined: results wrap modulo 2^N, and no saturation logic is instantiated.

## Test plan
All scenarios use N = 8, S = 2.
- Add 0x7F + 0x01, cin = 0 → 0x80, overflow = 1, carry = 0, zero = 0. With ADDER_PIPE_SAT_EN: result 0x7F, overflow = 1.
- Add 0xFF + 0x01, cin = 0 → 0x00, carry = 1, zero = 1, overflow = 0. Sub 0x05 − 0x05, cin = 0 → 0x00, carry = 0, zero = 1.
- Sub 0x03 − 0x05, cin = 0 → 0xFE, carry = 1 (borrow), overflow = 0. Sub 0x80 − 0x01 → 0x7F, overflow = 1; with SAT: 0x80.
- Streaming and back-pressure: 16 back-to-back random beats with out_ready toggled by an LFSR.
  - Results match a reference model, in order, with no loss or duplication.
  - Latency is exactly 2 cycles when out_ready is held at 1.
- Chaining: 16-bit add 0x00FF + 0x0001 run as two 8-bit beats, with the low beat's carry fed to the high beat's cin. Low → 0x00, carry = 1; high → 0x01, giving 0x0100.
- Reset mid-operation: assert rst with 2 beats in flight.
  - Next cycle: out_valid = 0 and all outputs 0.
  - Neither beat ever appears.
  - in_ready = 1 in the cycle after rst deasserts.

Source files
------------

// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : adder_pipe
// Description : Pipelined N-bit adder/subtractor with carry/borrow-in and
//               Carry/Zero/Overflow flags. The operands are split into S
//               chunks of W = N/S bits; stage k resolves chunk k-1 using the
//               carry registered by the previous stage. One result per cycle
//               at S-cycle latency. N must be a multiple of S, S >= 1.
// Ports       : clk, rst (sync, active-high)
//               in_valid/in_ready   operand handshake
//               in_sub, in_cin      0: A+B+cin, 1: A-B-cin
//               in_a, in_b          N-bit operands
//               out_valid/out_ready result handshake
//               out_result          N-bit result
//               out_carry           carry-out (add) / borrow-out (sub)
//               out_zero            out_result == 0
//               out_overflow        signed two's-complement overflow
// Config      : ADDER_PIPE_SAT_EN  signed saturation of the delivered result
// Revision    : 1.0  initial release
// ============================================================================
module adder_pipe #(
    parameter int N = 32,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sub,
    input  logic         in_cin,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         out_carry,
    output logic         out_zero,
    output logic         out_overflow
);

    localparam int W = N / S;

    // Global advance: the whole pipe moves when the output slot is free or
    // being drained this cycle.
    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Index k holds the beat as seen at the input of stage k+1. Index 0 is
    // the port side; indices 1..S-1 are the inter-stage registers.
    logic         w_v    [S];
    logic         w_sub  [S];
    logic         w_c    [S];
    logic [N-1:0] w_a    [S];
    logic [N-1:0] w_be   [S];
    logic [N-1:0] w_r    [S];
    logic [W:0]   w_sum  [S];
    logic [N-1:0] w_rn   [S];

    // Subtraction is A + ~B + ~borrow_in, so the effective carry-in is
    // in_cin ^ in_sub.
    assign w_v[0]   = in_valid;
    assign w_sub[0] = in_sub;
    assign w_c[0]   = in_cin ^ in_sub;
    assign w_a[0]   = in_a;
    assign w_be[0]  = in_sub ? ~in_b : in_b;
    assign w_r[0]   = '0;

    // Chunk adders: stage k+1 resolves chunk k and merges it into the
    // partial result (those bits are still zero at this point).
    genvar k;
    generate
        for (k = 0; k < S; k++) begin : g_chunk
            assign w_sum[k] = {1'b0, w_a[k][k*W +: W]}
                            + {1'b0, w_be[k][k*W +: W]}
                            + {{W{1'b0}}, w_c[k]};
            assign w_rn[k]  = w_r[k] | (N'(w_sum[k][W-1:0]) << (k*W));
        end
    endgenerate

    // Inter-stage registers: operands travel along with the partial result
    // and the chunk carry.
    generate
        for (k = 1; k < S; k++) begin : g_stage
            logic         r_valid_q;
            logic         r_sub_q;
            logic         r_carry_q;
            logic [N-1:0] r_a_q;
            logic [N-1:0] r_be_q;
            logic [N-1:0] r_res_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid_q <= 1'b0;
                    r_sub_q   <= 1'b0;
                    r_carry_q <= 1'b0;
                    r_a_q     <= '0;
                    r_be_q    <= '0;
                    r_res_q   <= '0;
                end else if (w_adv) begin
                    r_valid_q <= w_v[k-1];
                    r_sub_q   <= w_sub[k-1];
                    r_carry_q <= w_sum[k-1][W];
                    r_a_q     <= w_a[k-1];
                    r_be_q    <= w_be[k-1];
                    r_res_q   <= w_rn[k-1];
                end
            end

            assign w_v[k]   = r_valid_q;
            assign w_sub[k] = r_sub_q;
            assign w_c[k]   = r_carry_q;
            assign w_a[k]   = r_a_q;
            assign w_be[k]  = r_be_q;
            assign w_r[k]   = r_res_q;
        end
    endgenerate

    // Final stage: flags from the completed raw sum.
    logic         w_cout;
    logic [N-1:0] w_raw;
    logic         w_ovf;
    logic [N-1:0] w_res_d;

    assign w_cout = w_sum[S-1][W];
    assign w_raw  = w_rn[S-1];
    assign w_ovf  = (w_a[S-1][N-1] == w_be[S-1][N-1]) && (w_raw[N-1] != w_a[S-1][N-1]);

`ifdef ADDER_PIPE_SAT_EN
    // Overflow direction follows the sign of A: negative A clamps to the
    // most negative value, positive A to the most positive.
    assign w_res_d = w_ovf ? (w_a[S-1][N-1] ? {1'b1, {(N-1){1'b0}}}
                                            : {1'b0, {(N-1){1'b1}}})
                           : w_raw;
`else
    assign w_res_d = w_raw;
`endif

    logic         r_out_valid_q;
    logic [N-1:0] r_out_result_q;
    logic         r_out_carry_q;
    logic         r_out_zero_q;
    logic         r_out_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid_q  <= 1'b0;
            r_out_result_q <= '0;
            r_out_carry_q  <= 1'b0;
            r_out_zero_q   <= 1'b0;
            r_out_ovf_q    <= 1'b0;
        end else if (w_adv) begin
            r_out_valid_q  <= w_v[S-1];
            r_out_result_q <= w_res_d;
            r_out_carry_q  <= w_cout ^ w_sub[S-1];
            r_out_zero_q   <= ~|w_res_d;
            r_out_ovf_q    <= w_ovf;
        end
    end

    assign out_valid    = r_out_valid_q;
    assign out_result   = r_out_result_q;
    assign out_carry    = r_out_carry_q;
    assign out_zero     = r_out_zero_q;
    assign out_overflow = r_out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_pipe
// Description : Self-checking bench for adder_pipe (N = 8, S = 2). Expected
//               results come from integer arithmetic on the operands; a
//               single negedge process compares every delivered beat in
//               order, plus directed, chaining and reset scenarios.
// Revision    : 1.0  initial release
// ============================================================================
module tb_adder_pipe;

    localparam int N = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_sub = 1'b0;
    logic         in_cin = 1'b0;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic         out_carry;
    logic         out_zero;
    logic         out_overflow;

    adder_pipe #(.N(N), .S(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sub       (in_sub),
        .in_cin       (in_cin),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_zero     (out_zero),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit lat_chk    = 1'b0;

    // out_ready source: fixed level or LFSR bit
    logic       ready_fix = 1'b1;
    bit         lfsr_en   = 1'b0;
    logic [7:0] lfsr      = 8'hA5;
    assign out_ready = lfsr_en ? lfsr[0] : ready_fix;

    always @(posedge clk) begin
        cyc++;
        #1;
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       o;
        int         acc;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, signed range check for overflow.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic s, input logic ci);
        exp_t e;
        int full;
        int sa;
        int sb;
        int sr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            full = int'(a) - int'(b) - int'(ci);
            sr   = sa - sb - int'(ci);
            e.c  = (full < 0);
        end else begin
            full = int'(a) + int'(b) + int'(ci);
            sr   = sa + sb + int'(ci);
            e.c  = (full > 255);
        end
        e.res = full[7:0];
        e.o   = (sr > 127) || (sr < -128);
`ifdef ADDER_PIPE_SAT_EN
        if (e.o) e.res = (sr > 127) ? 8'h7F : 8'h80;
`endif
        e.z   = (e.res == 8'h00);
        e.acc = 0;
        return e;
    endfunction

    // Compare process
    bit         stall = 1'b0;
    logic [7:0] p_res;
    logic       p_c, p_z, p_o;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stall = 1'b0;
        end else begin
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (stall)
                chk("stall_hold", {21'd0, out_result, out_carry, out_zero, out_overflow},
                                  {21'd0, p_res, p_c, p_z, p_o});
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", {31'd0, out_valid}, 32'd0);
                end else if (out_ready) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result",   {24'd0, out_result},   {24'd0, e.res});
                    chk("carry",    {31'd0, out_carry},    {31'd0, e.c});
                    chk("zero",     {31'd0, out_zero},     {31'd0, e.z});
                    chk("overflow", {31'd0, out_overflow}, {31'd0, e.o});
                    if (lat_chk) chk("latency", cyc - e.acc, S);
                end
            end
            stall = out_valid && !out_ready;
            p_res = out_result; p_c = out_carry; p_z = out_zero; p_o = out_overflow;
            if (in_valid && in_ready) begin
                exp_t e;
                e = model(in_a, in_b, in_sub, in_cin);
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ci);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = s; in_cin = ci;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain_empty", q.size(), 32'd0);
    endtask

    task automatic pin(input string nm, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic ci, input logic [7:0] r, input logic c, input logic z, input logic o);
        exp_t e;
        e = model(a, b, s, ci);
        chk(nm, {21'd0, e.res, e.c, e.z, e.o}, {21'd0, r, c, z, o});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lo_res;
        logic       lo_c;
        int         n;

        // Hand-computed pins on the reference model
`ifdef ADDER_PIPE_SAT_EN
        pin("pin_7f_add_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        pin("pin_80_sub_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
`else
        pin("pin_7f_add_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
        pin("pin_80_sub_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
`endif
        pin("pin_ff_add_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        pin("pin_05_sub_05", 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        pin("pin_03_sub_05", 8'h03, 8'h05, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
        pin("pin_00_add_cin", 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", {24'd0, out_result}, 32'd0);
        chk("rst_flags", {29'd0, out_carry, out_zero, out_overflow}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors, ready held high: latency also checked
        @(posedge clk); #1;
        lat_chk = 1'b1;
        send(8'h7F, 8'h01, 1'b0, 1'b0);
        send(8'hFF, 8'h01, 1'b0, 1'b0);
        send(8'h05, 8'h05, 1'b1, 1'b0);
        send(8'h03, 8'h05, 1'b1, 1'b0);
        send(8'h80, 8'h01, 1'b1, 1'b0);
        send(8'h7F, 8'h80, 1'b1, 1'b1);
        send(8'h80, 8'h80, 1'b0, 1'b1);
        drain();

        // Random back-to-back, ready high
        for (int i = 0; i < 16; i++)
            send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        drain();

        // Random back-to-back with LFSR back-pressure
        lat_chk = 1'b0;
        lfsr_en = 1'b1;
        for (int i = 0; i < 16; i++)
            send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        lfsr_en = 1'b0;
        ready_fix = 1'b1;
        drain();

        // Chaining: 0x00FF + 0x0001 as two 8-bit beats
        send(8'hFF, 8'h01, 1'b0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("chain_lo_seen", {31'd0, out_valid}, 32'd1);
        lo_res = out_result;
        lo_c   = out_carry;
        chk("chain_lo", {23'd0, lo_c, lo_res}, {23'd0, 1'b1, 8'h00});
        @(posedge clk); #1;
        send(8'h00, 8'h00, 1'b0, lo_c);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("chain_16", {16'd0, out_result, lo_res}, 32'h0000_0100);
        drain();

        // Reset with two beats in flight
        @(posedge clk); #1;
        send(8'h11, 8'h22, 1'b0, 1'b0);
        send(8'h33, 8'h44, 1'b0, 1'b0);
        ready_fix = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ready_fix = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_outputs", {21'd0, out_result, out_carry, out_zero, out_overflow}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (6) @(negedge clk);
        chk("midrst_no_ghost", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
